// File: rtl/tile_bg_pipeline.sv
// Background-layer pixel pipeline: scroll with wrap, tilemap lookup, texture fetch, RGB444 out.
// Optional feature: define TILE_BG_TRANSPARENT_EN to map texture index 0 to BACKDROP_RGB.
module tile_bg_pipeline #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter logic [11:0] BACKDROP_RGB = 12'h000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  i_pixel_x,
    input  logic [9:0]  i_pixel_y,
    input  logic        i_pixel_valid,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [9:0]  i_scroll_x,
    input  logic [8:0]  i_scroll_y,
    output logic [5:0]  o_tilemap_x_idx,
    output logic [5:0]  o_tilemap_y_idx,
    input  logic [7:0]  i_tilemap_texture_idx,
    output logic [15:0] o_texture_addr,
    input  logic [11:0] i_texture_data,
    output logic [11:0] o_pixel_rgb,
    output logic        o_pixel_valid,
    output logic        o_hsync,
    output logic        o_vsync
);

    localparam logic [10:0] SCR_W11 = 11'(SCREEN_W);
    localparam logic [9:0]  SCR_W10 = 10'(SCREEN_W);
    localparam logic [9:0]  SCR_H10 = 10'(SCREEN_H);
    localparam logic [8:0]  SCR_H9  = 9'(SCREEN_H);

    logic [9:0]  scroll_x_q;
    logic [8:0]  scroll_y_q;
    logic        frame_start;
    logic [9:0]  scroll_x_norm;
    logic [8:0]  scroll_y_norm;
    logic [9:0]  scroll_x_eff;
    logic [8:0]  scroll_y_eff;
    logic [10:0] wx_sum;
    logic [9:0]  wy_sum;
    logic [9:0]  wx;
    logic [8:0]  wy;

    // Sideband bundles are {valid, hsync, vsync}
    logic [2:0]  side1_q, side2_q, side3_q, side4_q;
    logic [3:0]  fine1_x_q, fine1_y_q, fine2_x_q, fine2_y_q;
    logic        transp4;
    logic [11:0] rgb_next;

    always_comb begin
        frame_start   = i_pixel_valid && (i_pixel_x == 10'd0) && (i_pixel_y == 10'd0);
        scroll_x_norm = (i_scroll_x >= SCR_W10) ? (i_scroll_x - SCR_W10) : i_scroll_x;
        scroll_y_norm = (i_scroll_y >= SCR_H9) ? (i_scroll_y - SCR_H9) : i_scroll_y;
        // The frame's first pixel already uses the scroll being loaded this cycle.
        scroll_x_eff  = frame_start ? scroll_x_norm : scroll_x_q;
        scroll_y_eff  = frame_start ? scroll_y_norm : scroll_y_q;
        wx_sum        = {1'b0, i_pixel_x} + {1'b0, scroll_x_eff};
        wy_sum        = i_pixel_y + {1'b0, scroll_y_eff};
        wx            = (wx_sum >= SCR_W11) ? 10'(wx_sum - SCR_W11) : wx_sum[9:0];
        wy            = (wy_sum >= SCR_H10) ? 9'(wy_sum - SCR_H10) : wy_sum[8:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scroll_x_q      <= '0;
            scroll_y_q      <= '0;
            o_tilemap_x_idx <= '0;
            o_tilemap_y_idx <= '0;
            fine1_x_q       <= '0;
            fine1_y_q       <= '0;
            fine2_x_q       <= '0;
            fine2_y_q       <= '0;
            side1_q         <= '0;
            side2_q         <= '0;
            side3_q         <= '0;
            side4_q         <= '0;
            o_texture_addr  <= '0;
            o_pixel_rgb     <= '0;
            o_pixel_valid   <= 1'b0;
            o_hsync         <= 1'b0;
            o_vsync         <= 1'b0;
        end else begin
            if (frame_start) begin
                scroll_x_q <= scroll_x_norm;
                scroll_y_q <= scroll_y_norm;
            end
            // S1: tile request
            if (i_pixel_valid) begin
                o_tilemap_x_idx <= wx[9:4];
                o_tilemap_y_idx <= {1'b0, wy[8:4]};
            end
            fine1_x_q <= wx[3:0];
            fine1_y_q <= wy[3:0];
            side1_q   <= {i_pixel_valid, i_hsync, i_vsync};
            // S2: tilemap read in flight
            fine2_x_q <= fine1_x_q;
            fine2_y_q <= fine1_y_q;
            side2_q   <= side1_q;
            // S3: texture request
            if (side2_q[2]) begin
                o_texture_addr <= {i_tilemap_texture_idx, fine2_y_q, fine2_x_q};
            end
            side3_q <= side2_q;
            // S4: texture read in flight
            side4_q <= side3_q;
            // S5: pixel out
            o_pixel_rgb   <= rgb_next;
            o_pixel_valid <= side4_q[2];
            o_hsync       <= side4_q[1];
            o_vsync       <= side4_q[0];
        end
    end

`ifdef TILE_BG_TRANSPARENT_EN
    logic transp3_q, transp4_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            transp3_q <= 1'b0;
            transp4_q <= 1'b0;
        end else begin
            transp3_q <= side2_q[2] && (i_tilemap_texture_idx == 8'h00);
            transp4_q <= transp3_q;
        end
    end

    assign transp4 = transp4_q;
`else
    assign transp4 = 1'b0;
`endif

    always_comb begin
        rgb_next = '0;
        if (side4_q[2]) begin
            rgb_next = transp4 ? BACKDROP_RGB : i_texture_data;
        end
    end

endmodule

// File: tb/tb_tile_bg_pipeline.sv
// Scoreboard bench for tile_bg_pipeline: random pixels/scroll against a modular-arithmetic model.
module tb_tile_bg_pipeline;

    localparam logic [11:0] BACKDROP = 12'h123;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  i_pixel_x, i_pixel_y;
    logic        i_pixel_valid, i_hsync, i_vsync;
    logic [9:0]  i_scroll_x;
    logic [8:0]  i_scroll_y;
    logic [5:0]  o_tilemap_x_idx, o_tilemap_y_idx;
    logic [7:0]  tm_data;
    logic [15:0] o_texture_addr;
    logic [11:0] tex_data;
    logic [11:0] o_pixel_rgb;
    logic        o_pixel_valid, o_hsync, o_vsync;

    tile_bg_pipeline #(
        .SCREEN_W     (640),
        .SCREEN_H     (480),
        .BACKDROP_RGB (BACKDROP)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .i_pixel_x             (i_pixel_x),
        .i_pixel_y             (i_pixel_y),
        .i_pixel_valid         (i_pixel_valid),
        .i_hsync               (i_hsync),
        .i_vsync               (i_vsync),
        .i_scroll_x            (i_scroll_x),
        .i_scroll_y            (i_scroll_y),
        .o_tilemap_x_idx       (o_tilemap_x_idx),
        .o_tilemap_y_idx       (o_tilemap_y_idx),
        .i_tilemap_texture_idx (tm_data),
        .o_texture_addr        (o_texture_addr),
        .i_texture_data        (tex_data),
        .o_pixel_rgb           (o_pixel_rgb),
        .o_pixel_valid         (o_pixel_valid),
        .o_hsync               (o_hsync),
        .o_vsync               (o_vsync)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents
    logic [7:0] tilemap [0:1199];

    function automatic logic [11:0] texfn(input logic [15:0] a);
        logic [15:0] h;
        if (a == 16'h5A55) return 12'hABC;
        if (a[15:8] == 8'h00 && a[7:0] == 8'h37) return 12'hFFF;
        h = (a * 16'd2654) ^ (a >> 3) ^ 16'h0F3C;
        return h[11:0];
    endfunction

    // Synchronous memories: one-cycle read latency
    always @(posedge clk) begin
        int idx;
        idx = int'(o_tilemap_y_idx) * 40 + int'(o_tilemap_x_idx);
        tm_data  <= (idx < 1200) ? tilemap[idx] : 8'hEE;
        tex_data <= texfn(o_texture_addr);
    end

    typedef struct {
        int          due;
        logic        v, hs, vs;
        logic [11:0] rgb;
    } out_t;
    typedef struct {
        int         due;
        logic [5:0] tx, ty;
    } tm_t;
    typedef struct {
        int          due;
        logic [15:0] addr;
    } ta_t;

    out_t out_q[$];
    tm_t  tm_q[$];
    ta_t  ta_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: the scroll that applies to the current frame
    int msx = 0, msy = 0;

    task automatic issue(input int x, input int y, input logic v, input logic hs, input logic vs,
                         input int scx, input int scy);
        int          wx, wy;
        logic [7:0]  idx;
        logic [15:0] addr;
        logic [11:0] rgb;
        out_t        o;
        tm_t         t;
        ta_t         a;
        @(posedge clk);
        #1;
        i_pixel_x     = 10'(x);
        i_pixel_y     = 10'(y);
        i_pixel_valid = v;
        i_hsync       = hs;
        i_vsync       = vs;
        i_scroll_x    = 10'(scx);
        i_scroll_y    = 9'(scy);
        if (v && x == 0 && y == 0) begin
            msx = (scx >= 640) ? scx - 640 : scx;
            msy = (scy >= 480) ? scy - 480 : scy;
        end
        wx   = (x + msx) % 640;
        wy   = (y + msy) % 480;
        idx  = tilemap[(wy / 16) * 40 + wx / 16];
        addr = {idx, 4'(wy % 16), 4'(wx % 16)};
`ifdef TILE_BG_TRANSPARENT_EN
        rgb = (idx == 8'h00) ? BACKDROP : texfn(addr);
`else
        rgb = texfn(addr);
`endif
        o.due = cyc + 5;
        o.v   = v;
        o.hs  = hs;
        o.vs  = vs;
        o.rgb = v ? rgb : 12'h000;
        out_q.push_back(o);
        if (v) begin
            t.due  = cyc + 1;
            t.tx   = 6'(wx / 16);
            t.ty   = 6'(wy / 16);
            tm_q.push_back(t);
            a.due  = cyc + 3;
            a.addr = addr;
            ta_q.push_back(a);
        end
    endtask

    task automatic idle_inputs();
        i_pixel_valid = 1'b0;
        i_hsync       = 1'b0;
        i_vsync       = 1'b0;
    endtask

    // Monitor: compare whatever is due this cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (tm_q.size() > 0 && tm_q[0].due == cyc) begin
                tm_t t;
                t = tm_q.pop_front();
                check("tilemap_x", 32'(o_tilemap_x_idx), 32'(t.tx));
                check("tilemap_y", 32'(o_tilemap_y_idx), 32'(t.ty));
            end
            if (ta_q.size() > 0 && ta_q[0].due == cyc) begin
                ta_t a;
                a = ta_q.pop_front();
                check("texture_addr", 32'(o_texture_addr), 32'(a.addr));
            end
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                out_t o;
                o = out_q.pop_front();
                check("pixel_valid", 32'(o_pixel_valid), 32'(o.v));
                check("hsync", 32'(o_hsync), 32'(o.hs));
                check("vsync", 32'(o_vsync), 32'(o.vs));
                check("pixel_rgb", 32'(o_pixel_rgb), 32'(o.rgb));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx"}, 32'(o_tilemap_x_idx), 32'd0);
        check({tag, "_ty"}, 32'(o_tilemap_y_idx), 32'd0);
        check({tag, "_addr"}, 32'(o_texture_addr), 32'd0);
        check({tag, "_rgb"}, 32'(o_pixel_rgb), 32'd0);
        check({tag, "_valid"}, 32'(o_pixel_valid), 32'd0);
        check({tag, "_sync"}, 32'({o_hsync, o_vsync}), 32'd0);
    endtask

    task automatic random_frame(input int len);
        int scx, scy;
        scx = int'($urandom_range(0, 1023));
        scy = int'($urandom_range(0, 511));
        issue(0, 0, 1'b1, 1'($urandom), 1'($urandom), scx, scy);
        for (int i = 0; i < len; i++) begin
            int x, y;
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(0, 479));
            if ($urandom_range(0, 15) == 0) x = 639;
            if ($urandom_range(0, 15) == 0) y = 479;
            // Occasional (0,0) with valid low must not reload the scroll
            if ($urandom_range(0, 31) == 0) begin
                x = 0;
                y = 0;
                issue(x, y, 1'b0, 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            end else begin
                issue(x, y, ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1200; i++) begin
            tilemap[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
        tilemap[1 * 40 + 2] = 8'h5A;
        tilemap[0]          = 8'h00;

        reset_n    = 1'b0;
        i_pixel_x  = '0;
        i_pixel_y  = '0;
        i_scroll_x = '0;
        i_scroll_y = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Unscrolled: (37,21) -> tile (2,1), addr 5A55, rgb ABC
        issue(0, 0, 1'b1, 1'b0, 1'b1, 0, 0);
        issue(37, 21, 1'b1, 1'b1, 1'b0, 0, 0);
        // Transparent tile 0 with texture FFF at fine (7,3)
        issue(7, 3, 1'b1, 1'b0, 1'b0, 0, 0);
        issue(1, 1, 1'b0, 1'b1, 1'b1, 0, 0);
        // Horizontal wrap: scroll_x 630, pixel (15,0) -> wx 5
        issue(0, 0, 1'b1, 1'b0, 1'b0, 630, 0);
        issue(15, 0, 1'b1, 1'b0, 1'b0, 630, 0);
        // Vertical normalisation: scroll_y 500 -> 20, y 470 -> wy 10
        issue(0, 0, 1'b1, 1'b0, 1'b0, 0, 500);
        issue(3, 470, 1'b1, 1'b0, 1'b0, 0, 500);
        // Mid-frame change ignored
        issue(100, 50, 1'b1, 1'b0, 1'b0, 300, 100);
        issue(101, 50, 1'b1, 1'b0, 1'b0, 300, 100);
        issue(0, 0, 1'b1, 1'b0, 1'b0, 300, 100);
        issue(101, 50, 1'b1, 1'b0, 1'b0, 0, 0);

        for (int f = 0; f < 6; f++) random_frame(250);

        // Asynchronous reset in the middle of a busy stream
        out_q.delete();
        tm_q.delete();
        ta_q.delete();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check_outputs_zero("async_reset");
        msx = 0;
        msy = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) issue(5, 5, 1'b0, 1'b0, 1'b0, 0, 0);
        issue(200, 300, 1'b1, 1'b1, 1'b0, 77, 33);
        for (int i = 0; i < 100; i++) begin
            issue(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                  ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
        end
        random_frame(200);

        @(posedge clk);
        #1;
        idle_inputs();
        for (int i = 0; i < 20 && (out_q.size() + tm_q.size() + ta_q.size()) > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("drain_pending", 32'(out_q.size() + tm_q.size() + ta_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_bg_pipeline.md
# tile_bg_pipeline

Background-layer pixel pipeline for the tile renderer. It takes the display timing stream (pixel coordinates plus sync), applies per-frame scroll with wrap-around, and drives the tile indices into the tilemap lookup. It then converts the returned texture index into a texture-memory address and emits an RGB444 pixel aligned with delayed sync and valid signals. It sits between the VGA timing generator and the layer mixer, wrapped around the tilemap and texture memories.

## Interface
Parameters:
- `SCREEN_W`, 640: visible width in pixels; 40 tiles of 16 px.
- `SCREEN_H`, 480: visible height in pixels; 30 tiles of 16 px.
- `BACKDROP_RGB`, 12'h000: colour substituted for transparent tiles (see Configuration).

Ports (clock and reset first):
- `clk`  in  1  single clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `i_pixel_x`  in  10  current pixel column, 0..639.
- `i_pixel_y`  in  10  current pixel row, 0..479.
- `i_pixel_valid`  in  1  active-video qualifier for this cycle.
- `i_hsync`, `i_vsync`  in  1 each  sync from the timing generator.
- `i_scroll_x`  in  10  horizontal scroll request.
- `i_scroll_y`  in  9  vertical scroll request.
- `o_tilemap_x_idx`  out  6  tile column 0..39, to the tilemap.
- `o_tilemap_y_idx`  out  6  tile row 0..29, to the tilemap.
- `i_tilemap_texture_idx`  in  8  texture index, valid one cycle after `o_tilemap_*`.
- `o_texture_addr`  out  16  `{texture_idx, fine_y[3:0], fine_x[3:0]}`.
- `i_texture_data`  in  12  RGB444, valid one cycle after `o_texture_addr`.
- `o_pixel_rgb`  out  12  background pixel colour.
- `o_pixel_valid`, `o_hsync`, `o_vsync`  out  1 each  sideband delayed to match `o_pixel_rgb`.

## Operation
- **Scroll shadow.** `scroll_x_q`/`scroll_y_q` load from the inputs only on a cycle with `i_pixel_valid`=1, x=0 and y=0. The new scroll applies from that same pixel onward. Mid-frame changes to `i_scroll_*` are ignored until the next frame start.
- **Scroll normalisation.** Values at or above the screen size have the size subtracted once at load:
  - x ≥ 640 → x−640.
  - y ≥ 480 → y−480.
- **World coordinates.**
  - wx = x + scroll_x_q, computed 11 bits wide; if ≥640, subtract 640.
  - wy = y + scroll_y_q, computed 10 bits wide; if ≥480, subtract 480.
- **Tile and fine fields.**
  - Tile x = wx[9:4]; tile y = {1'b0, wy[8:4]}.
  - fine_x = wx[3:0]; fine_y = wy[3:0]. Both are carried down the pipeline alongside the tile coordinates.
- **Pipeline stages.**
  - S1: register the tile indices onto `o_tilemap_*`; register fine_x/fine_y and the sideband.
  - S2: the tilemap returns its index; the block passes fine fields and sideband through.
  - S3: register `o_texture_addr`.
  - S4: texture memory returns data.
  - S5: register `o_pixel_rgb`.
- **Idle cycles.** When `i_pixel_valid`=0:
  - `o_tilemap_*` and `o_texture_addr` hold their last values.
  - The sideband still shifts, and `o_pixel_rgb` is forced to 0 at S5 for non-valid slots.
- **Sync pass-through.** `i_hsync`/`i_vsync` are delayed through the pipeline unmodified.

## Timing
- Latency from pixel inputs to `o_pixel_rgb`/`o_pixel_valid`/`o_hsync`/`o_vsync` is exactly 5 cycles.
- Throughput is one pixel per cycle with no stalls and no backpressure.
- `o_tilemap_*` are registered: they change 1 cycle after the inputs are sampled.
- `o_texture_addr` is registered at cycle N+3 for a pixel sampled at cycle N.
- Reset values: all outputs 0, scroll shadow 0, all pipeline valid bits 0.
- Reset mid-line: the pipeline is flushed; `o_pixel_valid` stays 0 until 5 cycles after the first valid input following deassertion.
- Frame-start and scroll coincidence: the pixel at (0,0) uses the newly loaded scroll, not the previous frame's.

## Configuration
- Macro: `TILE_BG_TRANSPARENT_EN`.
- **Defined.** A texture index of 8'h00 marks a transparent tile. The flag is carried to S5, and `o_pixel_rgb` = `BACKDROP_RGB` regardless of `i_texture_data`.
- **Undefined.** Index 0 is an ordinary texture, and `o_pixel_rgb` = `i_texture_data` for all valid pixels.

## Test plan
- **Unscrolled.** Stimulus: scroll 0,0; pixel (37,21) valid at cycle N. Response: `o_tilemap_x_idx`=2 and `o_tilemap_y_idx`=1 at N+1. With tilemap returning 8'h5A: `o_texture_addr`=16'h5A55 at N+3. With texture returning 12'hABC: `o_pixel_rgb`=12'hABC with `o_pixel_valid`=1 at N+5.
- **Horizontal wrap.** Stimulus: scroll_x=630 loaded at (0,0); pixel (15,0). Response: wx=5, tile x=0, fine_x=5.
- **Vertical wrap and normalisation.** Stimulus: scroll_y=500. Response: normalises to 20. Pixel y=470 gives wy=10, tile y=0, fine_y=10.
- **Mid-frame scroll change.** Stimulus: change `i_scroll_x` at pixel (100,50). Response: tile indices unchanged for the rest of the frame; the new value takes effect at the next (0,0).
- **Transparency.** Stimulus: tilemap index 0, texture 12'hFFF, `BACKDROP_RGB`=12'h123. Response: output 12'h123 with the macro defined, 12'hFFF without.
- **Async reset.** Stimulus: assert `reset_n` low mid-stream. Response: all outputs 0 immediately; after release with valid input, `o_pixel_valid` first rises exactly 5 cycles later.
